// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - AXI4-Lite bus interface (32-bit address/data) used by uart_tx_fifo
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - AXI4-Lite console UART: TX FIFO, baud divisor, 8N1 serializer
// Optional UART_SIM_PRINT_EN: echo each popped byte to the simulation console.
module uart_tx_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'ha00003f8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic      clk,
    input  logic      reset,
    axi_lite_if.slave s,
    output logic      tx
);
    localparam int unsigned    PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned    CW          = PW + 1;
    localparam logic [CW-1:0]  FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_ADDR, W_WAIT_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e      w_state_q, w_state_d;
    r_state_e      r_state_q, r_state_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d, div_lat_q, div_lat_d, baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          busy_q, busy_d, tx_q, tx_d;

    logic          aw_hs, w_hs, ar_hs, do_write, push, pop, bit_end, last_cycle;
    logic [31:0]   wr_addr, status;
    logic [15:0]   wr_data;
    logic          unused_wdata_hi;

    assign s.awready = (w_state_q == W_IDLE) || (w_state_q == W_WAIT_ADDR);
    assign s.wready  = (w_state_q == W_IDLE) || (w_state_q == W_WAIT_DATA);
    assign s.bvalid  = (w_state_q == W_RESP);
    assign s.bresp   = bresp_q;
    assign s.arready = (r_state_q == R_IDLE);
    assign s.rvalid  = (r_state_q == R_DATA);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign tx        = tx_q;

    assign unused_wdata_hi = ^s.wdata[31:16];

    assign aw_hs    = s.awvalid && s.awready;
    assign w_hs     = s.wvalid && s.wready;
    assign ar_hs    = s.arvalid && s.arready;
    // Whichever half arrives second supplies its value directly from the bus.
    assign wr_addr  = aw_hs ? s.awaddr : awaddr_q;
    assign wr_data  = w_hs ? s.wdata[15:0] : wdata_q;
    assign do_write = ((w_state_q == W_IDLE) && aw_hs && w_hs) ||
                      ((w_state_q == W_WAIT_ADDR) && aw_hs) ||
                      ((w_state_q == W_WAIT_DATA) && w_hs);

    assign bit_end    = (baud_q == div_lat_q - 16'd1);
    assign last_cycle = busy_q && bit_end && (bit_q == 4'd9);
    // Popping in the final stop-bit cycle makes consecutive frames gapless.
    assign pop        = (!busy_q || last_cycle) && (count_q != '0);
    assign push       = do_write && (wr_addr == BASE_ADDR) && ((count_q != FULL_COUNT) || pop);
    assign status     = {16'd0, 8'(count_q), 4'd0, ovf_q, busy_q, count_q == '0, count_q == FULL_COUNT};

    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ovf_d     = ovf_q;
        div_d     = div_q;
        div_lat_d = div_lat_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        tx_d      = tx_q;
        wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);

        if (aw_hs) awaddr_d = s.awaddr;
        if (w_hs)  wdata_d  = s.wdata[15:0];

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) w_state_d = W_RESP;
                else if (aw_hs)    w_state_d = W_WAIT_DATA;
                else if (w_hs)     w_state_d = W_WAIT_ADDR;
            end
            W_WAIT_ADDR: if (aw_hs)     w_state_d = W_RESP;
            W_WAIT_DATA: if (w_hs)      w_state_d = W_RESP;
            W_RESP:      if (s.bready)  w_state_d = W_IDLE;
            default:                    w_state_d = W_IDLE;
        endcase

        if (do_write) begin
            bresp_d = RESP_OKAY;
            if (wr_addr == BASE_ADDR) begin
                if (!push) begin
                    ovf_d   = 1'b1;
                    bresp_d = RESP_SLVERR;
                end
            end else if (wr_addr == BASE_ADDR + 32'd4) begin
                if (wr_data[3]) ovf_d = 1'b0;
            end else if (wr_addr == BASE_ADDR + 32'd8) begin
                div_d = (wr_data == 16'd0) ? 16'd1 : wr_data;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rresp_d   = RESP_OKAY;
                    if (s.araddr == BASE_ADDR)              rdata_d = 32'd0;
                    else if (s.araddr == BASE_ADDR + 32'd4) rdata_d = status;
                    else if (s.araddr == BASE_ADDR + 32'd8) rdata_d = {16'd0, div_q};
                    else begin
                        rdata_d = 32'd0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA:  if (s.rready) r_state_d = R_IDLE;
            default:               r_state_d = R_IDLE;
        endcase

        if (pop) begin
            busy_d    = 1'b1;
            tx_d      = 1'b0;
            shift_d   = {1'b1, mem_q[rptr_q]};
            bit_d     = 4'd0;
            baud_d    = 16'd0;
            div_lat_d = div_q;
        end else if (busy_q) begin
            if (bit_end) begin
                baud_d = 16'd0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_d = baud_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RESET;
            div_lat_q <= DIV_RESET;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '1;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data[7:0];
    end

`ifdef UART_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (!reset && pop) $write("%c", mem_q[rptr_q]);
    end
`else
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo: transaction model plus directed vectors
module tb_uart_tx_fifo;
    localparam logic [31:0] BASE    = 32'ha00003f8;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DIV_RST = 16'd16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;
    axi_lite_if bus();

    uart_tx_fifo #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
        .clk(clk), .reset(reset), .s(bus), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: byte queue, sticky flag, divisor, and one frame in flight.
    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = DIV_RST;
    bit          fr_active = 1'b0;
    logic [7:0]  fr_byte = 8'h00;
    int          fr_div = 1, fr_t = 0, n_pre = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    bit          m_aw_hs, m_w_hs, m_ar_hs, ending, m_pop;
    logic [31:0] m_awaddr = 0, m_wdata = 0, exp_rdata = 0;
    logic [1:0]  exp_bresp = 0, exp_rresp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] v;
        v       = 32'd0;
        v[15:8] = 8'(q.size());
        v[3]    = m_ovf;
        v[2]    = fr_active;
        v[1]    = (q.size() == 0);
        v[0]    = (q.size() == DEPTH);
        return v;
    endfunction

    function automatic logic m_tx();
        logic [9:0] fr;
        if (!fr_active) return 1'b1;
        fr = {1'b1, fr_byte, 1'b0};
        return fr[fr_t / fr_div];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ovf = 0; m_div = DIV_RST; fr_active = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        end else begin
            m_aw_hs = bus.awvalid && !aw_got && !b_pend;
            m_w_hs  = bus.wvalid && !w_got && !b_pend;
            m_ar_hs = bus.arvalid && !r_pend;
            if (b_pend && bus.bready) b_pend = 0;
            if (r_pend && bus.rready) r_pend = 0;
            if (m_ar_hs) begin
                r_pend = 1; exp_rresp = 2'b00;
                if (bus.araddr == BASE)              exp_rdata = 32'd0;
                else if (bus.araddr == BASE + 32'd4) exp_rdata = m_status();
                else if (bus.araddr == BASE + 32'd8) exp_rdata = {16'd0, m_div};
                else begin exp_rdata = 32'd0; exp_rresp = 2'b10; end
            end
            n_pre  = q.size();
            ending = fr_active && (fr_t + 1 == 10 * fr_div);
            m_pop  = (!fr_active || ending) && (n_pre > 0);
            if (m_pop) begin
                fr_byte = q.pop_front(); fr_div = int'(m_div); fr_t = 0; fr_active = 1;
            end else if (ending) fr_active = 0;
            else if (fr_active) fr_t++;
            if (m_aw_hs) begin aw_got = 1; m_awaddr = bus.awaddr; end
            if (m_w_hs)  begin w_got = 1;  m_wdata  = bus.wdata;  end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; exp_bresp = 2'b00;
                if (m_awaddr == BASE) begin
                    if (n_pre < DEPTH || m_pop) q.push_back(m_wdata[7:0]);
                    else begin m_ovf = 1; exp_bresp = 2'b10; end
                end else if (m_awaddr == BASE + 32'd4) begin
                    if (m_wdata[3]) m_ovf = 0;
                end else if (m_awaddr == BASE + 32'd8) begin
                    m_div = (m_wdata[15:0] == 16'd0) ? 16'd1 : m_wdata[15:0];
                end else exp_bresp = 2'b10;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", tx, m_tx());
            chk("awready", bus.awready, !aw_got && !b_pend);
            chk("wready", bus.wready, !w_got && !b_pend);
            chk("bvalid", bus.bvalid, b_pend);
            if (b_pend) chk("bresp", bus.bresp, exp_bresp);
            chk("arready", bus.arready, !r_pend);
            chk("rvalid", bus.rvalid, r_pend);
            if (r_pend) begin
                chk("rdata", bus.rdata, exp_rdata);
                chk("rresp", bus.rresp, exp_rresp);
            end
        end
    end

    // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input int lead,
                             output logic [1:0] resp, output int lat);
        int aw_start, w_start, n;
        bit aw_done, w_done, aw_hit, w_hit;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; n = 0; resp = 2'b11; lat = -1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.wdata   = data;
            bus.awvalid = !aw_done && (n >= aw_start);
            bus.wvalid  = !w_done && (n >= w_start);
            #1;
            aw_hit = bus.awvalid && bus.awready;
            w_hit  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done |= aw_hit;
            w_done  |= w_hit;
            n++;
        end
        @(negedge clk);
        bus.awvalid = 0;
        bus.wvalid  = 0;
        if (!(aw_done && w_done)) begin
            failures++;
            $display("FAIL write_handshake: addr %h not accepted within 50 cycles", addr);
            return;
        end
        for (int k = 0; k < 20; k++) begin
            if (bus.bvalid) begin resp = bus.bresp; lat = k; break; end
            @(negedge clk);
        end
        if (lat < 0) begin
            failures++;
            $display("FAIL write_resp: no bvalid within 20 cycles for addr %h", addr);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit hit;
        data = '1; resp = 2'b11; n = 0; hit = 0;
        while (!hit && n < 50) begin
            @(negedge clk);
            bus.araddr  = addr;
            bus.arvalid = 1;
            #1;
            hit = bus.arready;
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        bus.arvalid = 0;
        if (!hit) begin
            failures++;
            $display("FAIL read_handshake: addr %h not accepted within 50 cycles", addr);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            chk("rvalid_hold", bus.rvalid, 1'b1);
            @(negedge clk);
        end
        n = 0;
        while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
        if (!bus.rvalid) begin
            failures++;
            $display("FAIL read_resp: no rvalid within 20 cycles for addr %h", addr);
            return;
        end
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1;
        @(posedge clk);
        #1;
        bus.rready = 0;
    endtask

    // pat[i] is the expected line level during bit i of the frame (start bit first).
    task automatic check_frame(input logic [9:0] pat, input int div, input string nm);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: tx never went low within 100 cycles", nm);
            return;
        end
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? div / 2 : div) @(negedge clk);
            chk({nm, "_bit"}, tx, pat[i]);
        end
        repeat (div - div / 2) @(negedge clk);
        chk({nm, "_idle"}, tx, 1'b1);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          lat, n;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.awaddr = 0; bus.wdata = 0; bus.araddr = 0;
        bus.bready = 1; bus.rready = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        chk_en = 1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_wready", bus.wready, 1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 32'd0);
        axi_read(BASE + 4, 0, d, r);
        chk("rst_status", d, 32'h0000_0002);
        axi_read(BASE + 8, 0, d, r);
        chk("rst_div", d, 32'd16);

        axi_write(BASE, 32'h55, 0, r, lat);
        chk("t1_bresp", r, 2'b00);
        chk("t1_blat", lat, 0);
        check_frame(10'b1010101010, 16, "t1");

        axi_write(BASE + 8, 32'd4, 0, r, lat);
        chk("t2_div_bresp", r, 2'b00);
        axi_write(BASE, 32'h41, 2, r, lat);
        chk("t2_bresp", r, 2'b00);
        check_frame(10'b1010000010, 4, "t2");

        axi_write(BASE + 8, 32'd100, 0, r, lat);
        for (int i = 0; i < 6; i++) begin
            axi_write(BASE, 32'h30 + i, 0, r, lat);
            chk("t3_push_bresp", r, (i == 5) ? 2'b10 : 2'b00);
        end
        axi_read(BASE + 4, 0, d, r);
        chk("t3_status", d, 32'h0000_040D);
        axi_write(BASE + 4, 32'h8, 0, r, lat);
        chk("t3_clr_bresp", r, 2'b00);
        axi_read(BASE + 4, 0, d, r);
        chk("t3_status_clr", d, 32'h0000_0405);

        axi_read(BASE + 32'h10, 5, d, r);
        chk("t4_rresp", r, 2'b10);
        chk("t4_rdata", d, 32'd0);
        axi_write(BASE + 32'hC, 32'hFFFF, 0, r, lat);
        chk("t4_bresp", r, 2'b10);
        axi_read(BASE + 8, 0, d, r);
        chk("t4_div", d, 32'd100);
        axi_read(BASE + 4, 0, d, r);
        chk("t4_status", d, 32'h0000_0405);

        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        axi_write(BASE, 32'hA5, 0, r, lat);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("t5_start", tx, 1'b0);
        repeat (3 * 16 + 5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("t5_tx_after_reset", tx, 1'b1);
        reset = 0;
        axi_read(BASE + 4, 0, d, r);
        chk("t5_status", d, 32'h0000_0002);
        axi_read(BASE + 8, 0, d, r);
        chk("t5_div", d, 32'd16);

        axi_write(BASE + 8, 32'd0, 0, r, lat);
        axi_read(BASE + 8, 0, d, r);
        chk("t6_div_zero", d, 32'd1);
        axi_write(BASE, 32'h0F, 0, r, lat);
        check_frame(10'b1000011110, 1, "t6");

        axi_write(BASE + 8, 32'd2, 0, r, lat);
        axi_write(BASE, 32'h81, 0, r, lat);
        axi_write(BASE, 32'h7E, 0, r, lat);
        axi_write(BASE, 32'hC3, 0, r, lat);
        repeat (80) @(negedge clk);
        chk("t7_idle", tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
